// File: rtl/pool_pkg.sv
// Shared pool-unit definitions: line geometry, byte-count widths, packer FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pool_pkg;

    // Memory line geometry (MEM_DATA_BUS = 128 bits)
    localparam int BYTES_PER_LINE = 16;

    // Pool result stream: bytes per beat and the widths that carry byte counts
    localparam int POOL_MAX_BYTES_TO_WR      = 5;
    localparam int POOL_LOG2_MAX_BYTES_TO_WR = $clog2(POOL_MAX_BYTES_TO_WR);
    localparam int POOL_CNT_W                = POOL_LOG2_MAX_BYTES_TO_WR + 1;
    // Fill level of a line plus one beat can reach BYTES_PER_LINE + MAX - 1
    localparam int POOL_FILL_W               = $clog2(BYTES_PER_LINE) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } pkr_state_e;

endpackage

// File: rtl/pkr_byte_merge.sv
// Merges one input beat into a partially filled memory line; overflow goes to a residual.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is committed.
//
// Ports: line_i/fill_i current line and its byte count, beat_i/cnt_i the beat
// (cnt saturates at MAXB), line_o merged line, resid_o/resid_cnt_o overflow
// bytes starting at byte 0, sum_o = fill + saturated cnt, full_o = sum >= LINE_B.
module pkr_byte_merge
    import pool_pkg::*;
#(
    parameter int LINE_B = BYTES_PER_LINE,
    parameter int MAXB   = POOL_MAX_BYTES_TO_WR,
    parameter int CNT_W  = POOL_CNT_W,
    parameter int FILL_W = POOL_FILL_W
) (
    input  logic [LINE_B*8-1:0] line_i,
    input  logic [FILL_W-1:0]   fill_i,
    input  logic [MAXB*8-1:0]   beat_i,
    input  logic [CNT_W-1:0]    cnt_i,
    output logic [LINE_B*8-1:0] line_o,
    output logic [MAXB*8-1:0]   resid_o,
    output logic [FILL_W-1:0]   resid_cnt_o,
    output logic [FILL_W-1:0]   sum_o,
    output logic                full_o
);

    logic [CNT_W-1:0] cnt_sat;

    always_comb begin : merge_p
        int pos;
        pos         = 0;
        cnt_sat     = (cnt_i > CNT_W'(MAXB)) ? CNT_W'(MAXB) : cnt_i;
        sum_o       = fill_i + FILL_W'(cnt_sat);
        full_o      = (sum_o >= FILL_W'(LINE_B));
        resid_cnt_o = full_o ? (sum_o - FILL_W'(LINE_B)) : '0;
        line_o      = line_i;
        resid_o     = '0;
        // Bytes past cnt are never copied, so unused line bytes keep their zero value
        for (int j = 0; j < MAXB; j++) begin
            if (j < int'(cnt_sat)) begin
                pos = int'(fill_i) + j;
                if (pos < LINE_B) begin
                    line_o[pos*8 +: 8] = beat_i[j*8 +: 8];
                end else if (pos - LINE_B < MAXB) begin
                    resid_o[(pos-LINE_B)*8 +: 8] = beat_i[j*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/pool_wr_packer.sv
// Packs the pool result byte stream into memory lines and writes them from the programmed address.
// Latency: req the cycle after the line-completing beat; done the cycle after the final gnt.
// Backpressure: in_ready drops while a line write waits for mem_wr_gnt; req/addr/data/be hold.
//
// Ports: sw_pool_wr_addr/pkr_start/pkr_busy/pkr_done/pkr_lines_wr job control,
// in_valid/in_ready/in_data/in_cnt/in_last byte stream (byte 0 first),
// mem_wr_req/addr/data/be/gnt memory write client (all outputs registered).
module pool_wr_packer
    import pool_pkg::*;
#(
    parameter int ADDR_WIDTH           = 12,
    parameter int MEM_DATA_BUS         = 128,
    parameter int MAX_BYTES_TO_WR      = 5,
    parameter int LOG2_MAX_BYTES_TO_WR = $clog2(MAX_BYTES_TO_WR)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [ADDR_WIDTH-1:0]             sw_pool_wr_addr,
    input  logic                              pkr_start,
    output logic                              pkr_busy,
    output logic                              pkr_done,
    output logic [ADDR_WIDTH-1:0]             pkr_lines_wr,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [MAX_BYTES_TO_WR*8-1:0]      in_data,
    input  logic [LOG2_MAX_BYTES_TO_WR:0]     in_cnt,
    input  logic                              in_last,
    output logic                              mem_wr_req,
    output logic [ADDR_WIDTH-1:0]             mem_wr_addr,
    output logic [MEM_DATA_BUS-1:0]           mem_wr_data,
    output logic [MEM_DATA_BUS/8-1:0]         mem_wr_be,
    input  logic                              mem_wr_gnt
);

    localparam int LINE_B = MEM_DATA_BUS / 8;
    localparam int MAXB   = MAX_BYTES_TO_WR;
    localparam int CNT_W  = LOG2_MAX_BYTES_TO_WR + 1;
    localparam int FILL_W = $clog2(LINE_B) + 1;

    pkr_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LINE_B*8-1:0]       line_q, line_d;
    logic [FILL_W-1:0]         fill_q, fill_d;
    logic [MAXB*8-1:0]         resid_q, resid_d;
    logic [FILL_W-1:0]         resid_cnt_q, resid_cnt_d;
    logic                      last_q, last_d;
    logic [ADDR_WIDTH-1:0]     lines_wr_q, lines_wr_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      in_ready_q, in_ready_d;
    logic                      req_q, req_d;
    logic [LINE_B*8-1:0]       data_q, data_d;
    logic [LINE_B-1:0]         be_q, be_d;

    logic [LINE_B*8-1:0]       m_line;
    logic [MAXB*8-1:0]         m_resid;
    logic [FILL_W-1:0]         m_resid_cnt;
    logic [FILL_W-1:0]         m_sum;
    logic                      m_full;
    logic [LINE_B*8-1:0]       resid_ext;

    assign resid_ext = {{((LINE_B - MAXB) * 8){1'b0}}, resid_q};

    function automatic logic [LINE_B-1:0] be_mask(input logic [FILL_W-1:0] n);
        logic [LINE_B-1:0] m;
        m = '0;
        for (int k = 0; k < LINE_B; k++) begin
            if (k < int'(n)) m[k] = 1'b1;
        end
        return m;
    endfunction

    pkr_byte_merge #(
        .LINE_B (LINE_B),
        .MAXB   (MAXB),
        .CNT_W  (CNT_W),
        .FILL_W (FILL_W)
    ) u_merge (
        .line_i      (line_q),
        .fill_i      (fill_q),
        .beat_i      (in_data),
        .cnt_i       (in_cnt),
        .line_o      (m_line),
        .resid_o     (m_resid),
        .resid_cnt_o (m_resid_cnt),
        .sum_o       (m_sum),
        .full_o      (m_full)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        line_d      = line_q;
        fill_d      = fill_q;
        resid_d     = resid_q;
        resid_cnt_d = resid_cnt_q;
        last_d      = last_q;
        lines_wr_d  = lines_wr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        in_ready_d  = in_ready_q;
        req_d       = req_q;
        data_d      = data_q;
        be_d        = be_q;

        unique case (state_q)
            IDLE: begin
                if (pkr_start) begin
                    state_d     = FILL;
                    wr_ptr_d    = sw_pool_wr_addr;
                    line_d      = '0;
                    fill_d      = '0;
                    resid_d     = '0;
                    resid_cnt_d = '0;
                    last_d      = 1'b0;
                    lines_wr_d  = '0;
                    busy_d      = 1'b1;
                    in_ready_d  = 1'b1;
                end
            end
            FILL: begin
                // in_ready_q is high throughout FILL, so in_valid alone means accepted
                if (in_valid) begin
                    last_d = in_last;
                    if (m_full) begin
                        state_d     = WRITE;
                        in_ready_d  = 1'b0;
                        req_d       = 1'b1;
                        data_d      = m_line;
                        be_d        = '1;
                        resid_d     = m_resid;
                        resid_cnt_d = m_resid_cnt;
                    end else if (in_last && (m_sum != '0)) begin
                        state_d     = WRITE;
                        in_ready_d  = 1'b0;
                        req_d       = 1'b1;
                        data_d      = m_line;
                        be_d        = be_mask(m_sum);
                        resid_d     = '0;
                        resid_cnt_d = '0;
                    end else if (in_last) begin
                        state_d    = DONE;
                        in_ready_d = 1'b0;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        line_d = m_line;
                        fill_d = m_sum;
                    end
                end
            end
            WRITE: begin
                if (mem_wr_gnt) begin
                    wr_ptr_d   = wr_ptr_q + ADDR_WIDTH'(1);
                    lines_wr_d = lines_wr_q + ADDR_WIDTH'(1);
                    // Overflow bytes become the head of the next line
                    line_d     = resid_ext;
                    fill_d     = resid_cnt_q;
                    if (last_q && (resid_cnt_q != '0)) begin
                        // Final partial line goes out immediately, req stays high
                        data_d      = resid_ext;
                        be_d        = be_mask(resid_cnt_q);
                        resid_d     = '0;
                        resid_cnt_d = '0;
                    end else begin
                        req_d  = 1'b0;
                        data_d = '0;
                        be_d   = '0;
                        if (last_q) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            state_d    = FILL;
                            in_ready_d = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            line_q      <= '0;
            fill_q      <= '0;
            resid_q     <= '0;
            resid_cnt_q <= '0;
            last_q      <= 1'b0;
            lines_wr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            req_q       <= 1'b0;
            data_q      <= '0;
            be_q        <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            line_q      <= line_d;
            fill_q      <= fill_d;
            resid_q     <= resid_d;
            resid_cnt_q <= resid_cnt_d;
            last_q      <= last_d;
            lines_wr_q  <= lines_wr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            in_ready_q  <= in_ready_d;
            req_q       <= req_d;
            data_q      <= data_d;
            be_q        <= be_d;
        end
    end

    assign pkr_busy     = busy_q;
    assign pkr_done     = done_q;
    assign pkr_lines_wr = lines_wr_q;
    assign in_ready     = in_ready_q;
    assign mem_wr_req   = req_q;
    assign mem_wr_addr  = wr_ptr_q;
    assign mem_wr_data  = data_q;
    assign mem_wr_be    = be_q;

endmodule
